// File: rtl/msrv32_integer_file.sv
// -----------------------------------------------------------------------------
// msrv32_integer_file
//
// Integer register file for the RV32I core: DEPTH architectural registers of
// WIDTH bits, two combinational read ports and one clocked write port.
// Register x0 is hardwired to zero and has no storage.
//
// Ports:
//   ms_riscv32_mp_clk_in  core clock; writes occur on the rising edge
//   ms_riscv32_mp_rst_in  asynchronous active-low reset, clears all registers
//   rs_1_addr_in          read address, port 1 (rs1 field)
//   rs_2_addr_in          read address, port 2 (rs2 field)
//   rd_addr_in            write address (rd from write-back)
//   wr_en_in              write enable from write-back
//   flush_in              pipeline flush; suppresses the write this cycle
//   rd_in                 write data
//   rs_1_out              contents of register rs_1_addr_in
//   rs_2_out              contents of register rs_2_addr_in
//
// Configuration:
//   MSRV32_RF_BYPASS_EN   when defined, a qualifying write is forwarded
//                         combinationally to any read port addressing the same
//                         register in the same cycle. When undefined, reads
//                         return stored contents only.
// -----------------------------------------------------------------------------
module msrv32_integer_file #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 32,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    input  logic [AW-1:0]    rs_1_addr_in,
    input  logic [AW-1:0]    rs_2_addr_in,
    input  logic [AW-1:0]    rd_addr_in,
    input  logic             wr_en_in,
    input  logic             flush_in,
    input  logic [WIDTH-1:0] rd_in,
    output logic [WIDTH-1:0] rs_1_out,
    output logic [WIDTH-1:0] rs_2_out
);

    // Storage for x1..x(DEPTH-1); x0 is never stored.
    logic [WIDTH-1:0] regs_q [1:DEPTH-1];
    logic [WIDTH-1:0] regs_d [1:DEPTH-1];

    // A write qualifies only out of reset, enabled, not flushed and not to x0.
    // Gating on reset keeps a bypassed value from leaking onto the read ports
    // while the block is held in reset.
    logic wr_qual;

    always_comb begin
        wr_qual = ms_riscv32_mp_rst_in && wr_en_in && !flush_in &&
                  (rd_addr_in != '0);
    end

    // Next-state: hold everything, overwrite only the addressed register.
    always_comb begin
        for (int unsigned i = 1; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_qual && (rd_addr_in == AW'(i))) begin
                regs_d[i] = rd_in;
            end
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read port 1: address 0 (and any address beyond DEPTH-1) returns zero.
    always_comb begin
        rs_1_out = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (rs_1_addr_in == AW'(i)) begin
                rs_1_out = regs_q[i];
            end
        end
`ifdef MSRV32_RF_BYPASS_EN
        // wr_qual already excludes x0, so x0 is never forwarded.
        if (wr_qual && (rd_addr_in == rs_1_addr_in)) begin
            rs_1_out = rd_in;
        end
`endif
    end

    // Read port 2: identical to port 1, bypassing independently.
    always_comb begin
        rs_2_out = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (rs_2_addr_in == AW'(i)) begin
                rs_2_out = regs_q[i];
            end
        end
`ifdef MSRV32_RF_BYPASS_EN
        if (wr_qual && (rd_addr_in == rs_2_addr_in)) begin
            rs_2_out = rd_in;
        end
`endif
    end

endmodule

// File: tb/tb_msrv32_integer_file.sv
// -----------------------------------------------------------------------------
// tb_msrv32_integer_file
//
// Directed self-checking bench for msrv32_integer_file. Each scenario task
// drives stimulus and compares outputs against hand-computed constants.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit after an input change or a rising edge.
// -----------------------------------------------------------------------------
module tb_msrv32_integer_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs_1_addr;
    logic [4:0]  rs_2_addr;
    logic [4:0]  rd_addr;
    logic        wr_en;
    logic        flush;
    logic [31:0] rd_data;
    logic [31:0] rs_1;
    logic [31:0] rs_2;

    int unsigned total = 0;
    int unsigned bad   = 0;

    msrv32_integer_file #(
        .WIDTH (32),
        .DEPTH (32)
    ) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .rs_1_addr_in         (rs_1_addr),
        .rs_2_addr_in         (rs_2_addr),
        .rd_addr_in           (rd_addr),
        .wr_en_in             (wr_en),
        .flush_in             (flush),
        .rd_in                (rd_data),
        .rs_1_out             (rs_1),
        .rs_2_out             (rs_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One qualifying write on the next rising edge; returns 1 unit after it.
    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        rd_addr = addr;
        rd_data = data;
        wr_en   = 1'b1;
        flush   = 1'b0;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
    endtask

    task automatic test_reset;
        // Reset has been asserted since time 0.
        rs_1_addr = 5'd5;
        rs_2_addr = 5'd31;
        #1;
        total++;
        if (rs_1 !== 32'h0) begin bad++; $display("FAIL reset_init_rs1 got=%h exp=%h", rs_1, 32'h0); end
        total++;
        if (rs_2 !== 32'h0) begin bad++; $display("FAIL reset_init_rs2 got=%h exp=%h", rs_2, 32'h0); end

        @(negedge clk);
        rst_n = 1'b1;
        write_reg(5'd5, 32'hDEADBEEF);
        rs_1_addr = 5'd5;
        rs_2_addr = 5'd5;
        #1;
        total++;
        if (rs_1 !== 32'hDEADBEEF) begin bad++; $display("FAIL preload_x5 got=%h exp=%h", rs_1, 32'hDEADBEEF); end

        // Assert reset between edges; outputs must clear without a clock.
        rst_n = 1'b0;
        #1;
        total++;
        if (rs_1 !== 32'h0) begin bad++; $display("FAIL async_reset_rs1 got=%h exp=%h", rs_1, 32'h0); end
        total++;
        if (rs_2 !== 32'h0) begin bad++; $display("FAIL async_reset_rs2 got=%h exp=%h", rs_2, 32'h0); end

        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            rs_1_addr = 5'(a);
            rs_2_addr = 5'(31 - a);
            #1;
            total++;
            if (rs_1 !== 32'h0) begin bad++; $display("FAIL post_reset_rs1 addr=%0d got=%h exp=%h", a, rs_1, 32'h0); end
            total++;
            if (rs_2 !== 32'h0) begin bad++; $display("FAIL post_reset_rs2 addr=%0d got=%h exp=%h", 31 - a, rs_2, 32'h0); end
        end
    endtask

    task automatic test_write_read;
        @(posedge clk);
        #1;
        write_reg(5'd1, 32'd20);
        write_reg(5'd2, 32'd40);
        rs_1_addr = 5'd1;
        rs_2_addr = 5'd2;
        #1;
        total++;
        if (rs_1 !== 32'd20) begin bad++; $display("FAIL wr_x1 got=%0d exp=%0d", rs_1, 20); end
        total++;
        if (rs_2 !== 32'd40) begin bad++; $display("FAIL wr_x2 got=%0d exp=%0d", rs_2, 40); end
        total++;
        if (rs_1 + rs_2 !== 32'd60) begin bad++; $display("FAIL alu_sum got=%0d exp=%0d", rs_1 + rs_2, 60); end
        rs_1_addr = 5'd2;
        #1;
        total++;
        if (rs_1 !== 32'd40 || rs_2 !== 32'd40) begin
            bad++; $display("FAIL same_addr rs1=%0d rs2=%0d exp=%0d", rs_1, rs_2, 40);
        end
    endtask

    task automatic test_x0_protect;
        rs_1_addr = 5'd0;
        rs_2_addr = 5'd0;
        rd_addr   = 5'd0;
        rd_data   = 32'hFFFFFFFF;
        wr_en     = 1'b1;
        flush     = 1'b0;
        #1;
        total++;
        if (rs_1 !== 32'h0 || rs_2 !== 32'h0) begin
            bad++; $display("FAIL x0_before rs1=%h rs2=%h exp=%h", rs_1, rs_2, 32'h0);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        #1;
        total++;
        if (rs_1 !== 32'h0 || rs_2 !== 32'h0) begin
            bad++; $display("FAIL x0_after rs1=%h rs2=%h exp=%h", rs_1, rs_2, 32'h0);
        end
        rs_1_addr = 5'd1;
        rs_2_addr = 5'd2;
        #1;
        total++;
        if (rs_1 !== 32'd20 || rs_2 !== 32'd40) begin
            bad++; $display("FAIL x0_others rs1=%0d rs2=%0d exp=20/40", rs_1, rs_2);
        end
        rs_1_addr = 5'd31;
        rs_2_addr = 5'd5;
        #1;
        total++;
        if (rs_1 !== 32'h0 || rs_2 !== 32'h0) begin
            bad++; $display("FAIL x0_untouched rs1=%h rs2=%h exp=%h", rs_1, rs_2, 32'h0);
        end
    endtask

    task automatic test_gating;
        rs_1_addr = 5'd7;
        rs_2_addr = 5'd7;
        rd_addr   = 5'd7;
        rd_data   = 32'd99;
        wr_en     = 1'b1;
        flush     = 1'b1;
        #1;
        total++;
        if (rs_1 !== 32'h0) begin bad++; $display("FAIL flush_no_bypass got=%0d exp=%0d", rs_1, 0); end
        @(posedge clk);
        #1;
        total++;
        if (rs_1 !== 32'h0) begin bad++; $display("FAIL flush_x7 got=%0d exp=%0d", rs_1, 0); end
        flush   = 1'b0;
        wr_en   = 1'b0;
        rd_data = 32'd77;
        @(posedge clk);
        #1;
        total++;
        if (rs_1 !== 32'h0 || rs_2 !== 32'h0) begin
            bad++; $display("FAIL wren_x7 rs1=%0d rs2=%0d exp=%0d", rs_1, rs_2, 0);
        end
    endtask

    task automatic test_bypass;
        write_reg(5'd3, 32'd8);
        rs_1_addr = 5'd3;
        rs_2_addr = 5'd1;
        rd_addr   = 5'd3;
        rd_data   = 32'd15;
        wr_en     = 1'b1;
        flush     = 1'b0;
        #1;
`ifdef MSRV32_RF_BYPASS_EN
        total++;
        if (rs_1 !== 32'd15) begin bad++; $display("FAIL bypass_before got=%0d exp=%0d", rs_1, 15); end
`else
        total++;
        if (rs_1 !== 32'd8) begin bad++; $display("FAIL bypass_before got=%0d exp=%0d", rs_1, 8); end
`endif
        total++;
        if (rs_2 !== 32'd20) begin bad++; $display("FAIL bypass_other_port got=%0d exp=%0d", rs_2, 20); end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        #1;
        total++;
        if (rs_1 !== 32'd15) begin bad++; $display("FAIL bypass_after got=%0d exp=%0d", rs_1, 15); end
    endtask

    task automatic test_back_to_back;
        write_reg(5'd4, 32'h1111_1111);
        write_reg(5'd4, 32'h2222_2222);
        write_reg(5'd4, 32'h3333_3333);
        rs_1_addr = 5'd4;
        rs_2_addr = 5'd3;
        #1;
        total++;
        if (rs_1 !== 32'h3333_3333) begin bad++; $display("FAIL b2b_x4 got=%h exp=%h", rs_1, 32'h3333_3333); end
        total++;
        if (rs_2 !== 32'd15) begin bad++; $display("FAIL b2b_x3 got=%0d exp=%0d", rs_2, 15); end
    endtask

    task automatic test_reset_midstream;
        write_reg(5'd10, 32'hA0A0_A0A0);
        rs_1_addr = 5'd10;
        rs_2_addr = 5'd11;
        #1;
        total++;
        if (rs_1 !== 32'hA0A0_A0A0) begin bad++; $display("FAIL mid_x10_written got=%h exp=%h", rs_1, 32'hA0A0_A0A0); end
        rst_n   = 1'b0;
        rd_addr = 5'd11;
        rd_data = 32'hB1B1_B1B1;
        wr_en   = 1'b1;
        flush   = 1'b0;
        #1;
        total++;
        if (rs_1 !== 32'h0 || rs_2 !== 32'h0) begin
            bad++; $display("FAIL mid_in_reset rs1=%h rs2=%h exp=%h", rs_1, rs_2, 32'h0);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        write_reg(5'd12, 32'hC2C2_C2C2);
        #1;
        total++;
        if (rs_1 !== 32'h0) begin bad++; $display("FAIL mid_x10_cleared got=%h exp=%h", rs_1, 32'h0); end
        total++;
        if (rs_2 !== 32'h0) begin bad++; $display("FAIL mid_x11_dropped got=%h exp=%h", rs_2, 32'h0); end
        rs_1_addr = 5'd12;
        rs_2_addr = 5'd4;
        #1;
        total++;
        if (rs_1 !== 32'hC2C2_C2C2) begin bad++; $display("FAIL mid_x12_lands got=%h exp=%h", rs_1, 32'hC2C2_C2C2); end
        total++;
        if (rs_2 !== 32'h0) begin bad++; $display("FAIL mid_x4_cleared got=%h exp=%h", rs_2, 32'h0); end
    endtask

    initial begin
        rst_n     = 1'b0;
        rs_1_addr = '0;
        rs_2_addr = '0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        flush     = 1'b0;
        rd_data   = '0;

        test_reset();
        test_write_read();
        test_x0_protect();
        test_gating();
        test_bypass();
        test_back_to_back();
        test_reset_midstream();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
